opb_register_simulink2ppc_snap: RTL

//  OPB slave exposing a 64-bit fabric-side value to the PowerPC as read-only registers. It is the

---
 rtl/opb_register_simulink2ppc_snap.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/opb_register_simulink2ppc_snap.sv
// opb_register_simulink2ppc_snap
// Read-only OPB slave. Software reads a coherent 64-bit snapshot of a fabric value,
// plus a strobe counter and sticky/overrun status.
// Ports:
//   OPB_Clk, OPB_Rst            clock; synchronous active-high reset
//   OPB_ABus/BE/DBus/RNW/select OPB request; OPB_seqAddr is ignored
//   Sl_DBus, Sl_xferAck         registered read data and one-cycle acknowledge
//   Sl_errAck/retry/toutSup     constant 0
//   user_data_in, user_valid    fabric value and capture strobe
// Register map (byte offset): 0x00 DATA_LO, 0x04 DATA_HI, 0x08 STATUS, 0x0C CTRL (write only).
module opb_register_simulink2ppc_snap #(
    parameter logic [31:0] C_BASEADDR   = 32'h01002500,
    parameter logic [31:0] C_HIGHADDR   = 32'h010025FF,
    parameter int unsigned C_OPB_AWIDTH = 32,
    parameter int unsigned C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex6"
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
    input  logic                        OPB_RNW,
    input  logic                        OPB_select,
    input  logic                        OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
    output logic                        Sl_xferAck,
    output logic                        Sl_errAck,
    output logic                        Sl_retry,
    output logic                        Sl_toutSup,
    input  logic [63:0]                 user_data_in,
    input  logic                        user_valid
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [63:0]        live_q, live_d;
    logic [31:0]        snap_hi_q, snap_hi_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               sticky_q, sticky_d;
    logic               overrun_q, overrun_d;
    logic [31:0]        dbus_q, dbus_d;
    logic               ack_q, ack_d;

    logic               hit_c;
    logic               reg_space_c;
    logic [1:0]         word_idx_c;
    logic               rd_lo_c;
    logic               ctrl_clr_c;
    logic [31:0]        rd_data_c;

    // Address decode; only offsets 0x00-0x0F carry registers, the rest of the window reads 0.
    assign hit_c       = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
    assign reg_space_c = (OPB_ABus[24:27] == 4'd0);
    assign word_idx_c  = OPB_ABus[28:29];
    assign rd_lo_c     = (state_q == ST_IDLE) && hit_c && OPB_RNW && reg_space_c
                         && (word_idx_c == 2'd0);
    assign ctrl_clr_c  = (state_q == ST_IDLE) && hit_c && !OPB_RNW && reg_space_c
                         && (word_idx_c == 2'd3) && OPB_BE[3] && OPB_DBus[31];

    // Read mux over the current-cycle register state.
    always_comb begin
        rd_data_c = 32'd0;
        if (reg_space_c) begin
            case (word_idx_c)
                2'd0:    rd_data_c = live_q[31:0];
                2'd1:    rd_data_c = snap_hi_q;
                2'd2:    rd_data_c = {count_q, 14'd0, overrun_q, sticky_q};
                default: rd_data_c = 32'd0;
            endcase
        end
    end

    // Next-state: FSM, bus outputs and register side effects.
    always_comb begin
        state_d   = state_q;
        live_d    = live_q;
        snap_hi_d = snap_hi_q;
        count_d   = count_q;
        sticky_d  = sticky_q;
        overrun_d = overrun_q;
        dbus_d    = 32'd0;
        ack_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hit_c) begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                    dbus_d  = OPB_RNW ? rd_data_c : 32'd0;
                end
            end
            ST_ACK:  state_d = ST_HOLD;
            ST_HOLD: if (!OPB_select) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Read side effect first so a same-cycle strobe leaves sticky set.
        if (rd_lo_c) begin
            snap_hi_d = live_q[63:32];
            sticky_d  = 1'b0;
        end
        // Overrun looks at the pre-read sticky value.
        if (user_valid) begin
            live_d    = user_data_in;
            count_d   = count_q + CNT_W'(1);
            overrun_d = overrun_q | sticky_q;
            sticky_d  = 1'b1;
        end
        // Software clear wins over a same-cycle strobe (live still updates).
        if (ctrl_clr_c) begin
            count_d   = '0;
            sticky_d  = 1'b0;
            overrun_d = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state_q   <= ST_IDLE;
            live_q    <= '0;
            snap_hi_q <= '0;
            count_q   <= '0;
            sticky_q  <= 1'b0;
            overrun_q <= 1'b0;
            dbus_q    <= '0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            live_q    <= live_d;
            snap_hi_q <= snap_hi_d;
            count_q   <= count_d;
            sticky_q  <= sticky_d;
            overrun_q <= overrun_d;
            dbus_q    <= dbus_d;
            ack_q     <= ack_d;
        end
    end

    // Register bit k lands on Sl_DBus[31-k].
    assign Sl_DBus    = dbus_q;
    assign Sl_xferAck = ack_q;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    logic unused_ok;
    assign unused_ok = &{1'b0, OPB_seqAddr, OPB_ABus[30:31], OPB_DBus[0:30], OPB_BE[0:2],
                         (C_FAMILY != '0)};

endmodule
